display_value_port: RTL and testbench
=====================================

Name: display_value_port

Overview:
- CPU-side output port that sits directly upstream of the signed seven-segment BCD display driver.
- Accepts 8-bit two's-complement results written by the datapath and holds them in a pending register.
- Forwards the pending value to the driver's `num` input at a throttled update rate, so fast-changing results stay readable.
- A debounced push-button toggles a freeze mode that holds the displayed value while the CPU keeps writing.

Parameters:
- UPDATE_DIV, 5000000, clk cycles per display update tick (20 Hz at 100 MHz); minimum 2
- DEBOUNCE_CYCLES, 1000000, cycles freeze_btn must be stable before it is accepted (10 ms at 100 MHz); minimum 1

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write strobe from CPU output instruction, one cycle per write
- wr_data  input  8  signed value to display
- freeze_btn  input  1  raw, asynchronous, bouncy push-button
- num  output  8  registered value to the display driver
- frozen  output  1  1 = display held
- pending  output  1  1 = a written value has not yet been forwarded to num

Behaviour:
- Reset (async, active-high): num=8'h00, pending=0, frozen=0; pend_reg, tick counter, debounce counter and sync flops all cleared. Reset mid-operation discards any pending value.
- Write capture: on a clk edge with wr_en=1, pend_reg<=wr_data and pending<=1. Back-to-back writes overwrite; only the last value survives. There is no backpressure; writes are always accepted, including while frozen.
- Tick counter: div_cnt counts 0..UPDATE_DIV-1 and wraps; tick=(div_cnt==UPDATE_DIV-1). It free-runs regardless of freeze.
- Transfer: on a tick edge, if the pre-edge pending=1 and frozen=0, then num<=pend_reg (pre-edge value).
  - If wr_en=0 on that edge: pending<=0.
  - If wr_en=1 on that same edge: the old pend_reg goes to num, the new wr_data is captured, and pending stays 1.
  - If pending was 0 and a write lands on the tick edge: no transfer; the value goes out on the next tick.
- Latency: write to num is 1 to UPDATE_DIV cycles when not frozen.
- Debounce:
  - freeze_btn passes through a 2-flop synchronizer.
  - stable_cnt resets whenever the synchronized level differs from btn_state.
  - When the level has differed for DEBOUNCE_CYCLES consecutive cycles, btn_state<=level.
  - A 0->1 transition of btn_state toggles frozen; release does nothing.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Frozen: num holds. Writes continue to update pend_reg and pending. On unfreeze, the next tick forwards the latest pend_reg.
- Button press coincident with a tick: the frozen value used for that tick's decision is the pre-edge value.
- Width: num is a plain register; no arithmetic on the data path except the optional clamp.

Optional Feature:
- Macro DISP_CLAMP_EN.
- Defined: at transfer, a value of 8'h80 (-128) is written to num as 8'h81 (-127). This keeps magnitude within 7 bits, which the downstream converter requires.
- Undefined: pass-through; 8'h80 is forwarded unchanged.

Test Plan (UPDATE_DIV=4, DEBOUNCE_CYCLES=3):
- Assert rst mid-run after wr_data=8'h2A -> num=00, pending=0, frozen=0 immediately; after release, no transfer until a new write.
- Write 8'hF6 at cycle 0 from reset -> num=F6 at the cycle-3 tick edge, pending drops the same edge.
- Writes 05, 06, 07 on consecutive cycles before one tick -> num=07 only; 05 and 06 never appear.
- Write 11 pending, then write 22 exactly on the tick edge -> num=11 and pending=1; next tick gives num=22 and pending=0.
- Toggle freeze_btn high for 2 cycles -> frozen stays 0. Hold it high for 5 cycles -> frozen=1. Write 33 -> num unchanged across 3 ticks. Second debounced press -> frozen=0, num=33 at the next tick.
- Write 80 -> num=81 with DISP_CLAMP_EN defined, num=80 without.

Source files
------------

// File: rtl/display_value_port.sv
// display_value_port: CPU output port feeding the signed seven-segment BCD
// display driver. Buffers the latest write, forwards it at a throttled tick
// rate, and lets a debounced push-button freeze the displayed value.
// Optional build macro: DISP_CLAMP_EN (forward -128 as -127 at transfer).
module display_value_port #(
  parameter int unsigned UPDATE_DIV      = 5000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       freeze_btn,
  output logic [7:0] num,
  output logic       frozen,
  output logic       pending
);

  localparam int unsigned DIV_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPDATE_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       pend_reg;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  logic [1:0]       sync_q;
  logic             btn_level_c;
  logic             btn_state;
  logic [DEB_W-1:0] stable_cnt;
  logic [7:0]       xfer_val_c;

  assign tick_c      = (div_cnt == DIV_LAST);
  assign btn_level_c = sync_q[1];

  // Value presented to the driver at transfer, optionally clamped to 7-bit magnitude
  always_comb begin
    xfer_val_c = pend_reg;
`ifdef DISP_CLAMP_EN
    if (pend_reg == 8'h80) begin
      xfer_val_c = 8'h81;
    end
`else
`endif
  end

  // Free-running update divider; tick marks the last count of each period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Write capture and tick-gated transfer to the display register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_reg <= 8'h00;
      pending  <= 1'b0;
      num      <= 8'h00;
    end else begin
      if (wr_en) begin
        pend_reg <= wr_data;
      end
      if (tick_c && pending && !frozen) begin
        num     <= xfer_val_c;
        pending <= wr_en;
      end else if (wr_en) begin
        pending <= 1'b1;
      end
    end
  end

  // Two-flop synchronizer for the raw button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], freeze_btn};
    end
  end

  // Debounce: accept a new level after it has differed for DEBOUNCE_CYCLES cycles;
  // each accepted press toggles freeze
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_state  <= 1'b0;
      stable_cnt <= '0;
      frozen     <= 1'b0;
    end else if (btn_level_c == btn_state) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DEB_LAST) begin
      stable_cnt <= '0;
      btn_state  <= btn_level_c;
      if (btn_level_c) begin
        frozen <= ~frozen;
      end
    end else begin
      stable_cnt <= stable_cnt + DEB_W'(1);
    end
  end

endmodule

// File: tb/tb_display_value_port.sv
// tb_display_value_port: directed bench for display_value_port with
// UPDATE_DIV=4, DEBOUNCE_CYCLES=3. Ticks fall on every fourth edge after
// reset release (edges 3, 7, 11, ...). Honors DISP_CLAMP_EN for the -128 case.
module tb_display_value_port;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       freeze_btn;
  logic [7:0] num;
  logic       frozen;
  logic       pending;

  int checks = 0;
  int errors = 0;

  display_value_port #(
    .UPDATE_DIV     (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .freeze_btn(freeze_btn),
    .num       (num),
    .frozen    (frozen),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_num,
                         input logic e_pend, input logic e_frz);
    chk8({tag, ".num"}, num, e_num);
    chk1({tag, ".pending"}, pending, e_pend);
    chk1({tag, ".frozen"}, frozen, e_frz);
  endtask

  initial begin
    logic [7:0] clamp_exp;
`ifdef DISP_CLAMP_EN
    clamp_exp = 8'h81;
`else
    clamp_exp = 8'h80;
`endif
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; freeze_btn = 1'b0;
    cyc(2);
    chk_all("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // F6 written at edge 0, forwarded at edge 3 tick
    wr_en = 1'b1; wr_data = 8'hF6;
    cyc(1);
    wr_en = 1'b0;
    chk_all("f6_captured", 8'h00, 1'b1, 1'b0);
    cyc(2);
    chk_all("f6_before_tick", 8'h00, 1'b1, 1'b0);
    cyc(1);
    chk_all("f6_tick", 8'hF6, 1'b0, 1'b0);

    // 05,06,07 at edges 4..6; only 07 reaches num at edge 7
    wr_en = 1'b1; wr_data = 8'h05; cyc(1);
    chk8("burst_05", num, 8'hF6);
    wr_data = 8'h06; cyc(1);
    chk8("burst_06", num, 8'hF6);
    wr_data = 8'h07; cyc(1);
    wr_en = 1'b0;
    chk_all("burst_07_pre", 8'hF6, 1'b1, 1'b0);
    cyc(1);
    chk_all("burst_tick", 8'h07, 1'b0, 1'b0);

    // 11 at edge 8, 22 exactly on edge 11 tick
    wr_en = 1'b1; wr_data = 8'h11; cyc(1);
    wr_en = 1'b0; cyc(2);
    wr_en = 1'b1; wr_data = 8'h22; cyc(1);
    wr_en = 1'b0;
    chk_all("coincide_tick", 8'h11, 1'b1, 1'b0);
    cyc(3);
    chk_all("coincide_hold", 8'h11, 1'b1, 1'b0);
    cyc(1);
    chk_all("coincide_next", 8'h22, 1'b0, 1'b0);

    // Write 2A then reset asynchronously before any tick
    wr_en = 1'b1; wr_data = 8'h2A; cyc(1);
    wr_en = 1'b0;
    chk1("pre_rst.pending", pending, 1'b1);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 1'b0);
    cyc(1);
    rst = 1'b0;
    cyc(4);
    chk_all("post_rst_idle", 8'h00, 1'b0, 1'b0);

    // Short 2-cycle press at edges 4,5 is rejected
    freeze_btn = 1'b1; cyc(2);
    freeze_btn = 1'b0; cyc(5);
    chk1("glitch.frozen", frozen, 1'b0);

    // 5-cycle press at edges 11..15 freezes (accepted at edge 15)
    freeze_btn = 1'b1; cyc(4);
    chk1("press1_early.frozen", frozen, 1'b0);
    cyc(1);
    chk1("press1.frozen", frozen, 1'b1);
    freeze_btn = 1'b0;

    // 33 written at edge 16 while frozen; ticks 19,23,27 must not forward it
    wr_en = 1'b1; wr_data = 8'h33; cyc(1);
    wr_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk8("frozen_hold.num", num, 8'h00);
    end
    chk_all("frozen_end", 8'h00, 1'b1, 1'b1);

    // Second press at edges 29..33 unfreezes at edge 33; tick 35 forwards 33
    freeze_btn = 1'b1; cyc(5);
    freeze_btn = 1'b0;
    chk_all("press2", 8'h00, 1'b1, 1'b0);
    cyc(1);
    chk8("press2_pre_tick.num", num, 8'h00);
    cyc(1);
    chk_all("unfreeze_tick", 8'h33, 1'b0, 1'b0);

    // -128 at edge 36, forwarded at edge 39
    wr_en = 1'b1; wr_data = 8'h80; cyc(1);
    wr_en = 1'b0; cyc(3);
    chk_all("clamp", clamp_exp, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
